// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit the bus, request-to-send, shift one
// byte plus odd parity on device clock falls, then check the device ACK.
//
// state     | meaning
// IDLE      | waiting for tx_start
// INHIBIT   | holding PS2_CLK low
// RTS       | start bit on PS2_DAT, clock released, waiting for first device fall
// SEND      | driving data bits LSB first, then parity, then releasing for stop
// ACK       | sampling the device ACK on the next fall
// WAIT_IDLE | waiting for both lines to return high
// DONE      | one-cycle completion, tx_err = 00
// ERR       | one-cycle completion with error code, lines released
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [1:0] tx_err
);
  localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] INHIBIT_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LOAD   = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LOAD    = CW'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [8:0]      shift_q, shift_d;
  logic            clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic            fall, fail;
  logic [1:0]      fail_code;

  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    clk_s1_d   = ps2_clk_in;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_dat_in;
    dat_s2_d   = dat_s1_q;
    fail       = 1'b0;
    fail_code  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shift_d  = {~^tx_data, tx_data};
          busy_d   = 1'b1;
          err_d    = 2'b00;
          clk_oe_d = 1'b1;
          cnt_d    = INHIBIT_LOAD;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == '0) begin
          dat_oe_d = 1'b1;
          state_d  = S_RTS;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RTS: begin
        // clk_oe still set means this is the entry cycle: release and arm the start timer
        if (clk_oe_q) begin
          clk_oe_d = 1'b0;
          cnt_d    = START_LOAD;
        end else if (fall) begin
          state_d = S_SEND;
          idx_d   = '0;
          cnt_d   = XFER_LOAD;
        end else if (cnt_q == '0) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SEND: begin
        if (cnt_q == '0) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (fall) begin
            if (idx_q == 4'd9) begin
              dat_oe_d = 1'b0;
              state_d  = S_ACK;
            end else begin
              dat_oe_d = ~shift_q[idx_q];
              idx_d    = idx_q + 4'd1;
            end
          end
        end
      end
      S_ACK: begin
        if (cnt_q == '0) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (fall) begin
            if (!dat_s2_q) begin
              state_d = S_WAIT_IDLE;
            end else begin
              fail      = 1'b1;
              fail_code = 2'b01;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (cnt_q == '0) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (clk_s2_q && dat_s2_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = 2'b00;
          end
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
    if (fail) begin
      state_d  = S_ERR;
      done_d   = 1'b1;
      busy_d   = 1'b0;
      err_d    = fail_code;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 2'b00;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_err     = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on wired-AND lines, a frame
// model checked every settled cycle, and literal expectations for known bytes.
module tb_ps2_host_tx;
  localparam int INH   = 40;
  localparam int START = 300;
  localparam int XFER  = 2000;
  localparam int H     = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done;
  logic [1:0] tx_err;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_line = dev_dat & ~ps2_dat_oe;

  int checks = 0, failures = 0;
  int cyc = 0, fall_count = 0, last_fall_cyc = 0, rel_cyc = 0, done_cyc = 0;
  bit mon_en = 1'b0;
  logic [7:0]  model_data = 8'h00;
  logic [12:1] cap;
  logic        got_done, d_busy, d_coe, d_doe, d_next;
  logic [1:0]  d_err;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(START), .XFER_TIMEOUT(XFER)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Host pull on PS2_DAT after n device falls since the clock was released.
  function automatic logic exp_dat_oe(input int n, input logic [7:0] d);
    logic [8:0] frame;
    frame = {~^d, d};
    if (n <= 1)  return 1'b1;
    if (n <= 10) return ~frame[n-2];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (mon_en && tx_busy && (cyc - last_fall_cyc) >= 4) begin
      chk("clk_oe_after_release", {31'd0, ps2_clk_oe}, 32'd0);
      chk("dat_oe_frame", {31'd0, ps2_dat_oe}, {31'd0, exp_dat_oe(fall_count, model_data)});
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(posedge clk); #1;
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic dev_run(input int max_falls, input bit do_ack);
    int n;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("inhibit_start", {31'd0, ps2_clk_oe}, 32'd1);
    n = 0;
    for (int i = 0; i < INH + 100; i++) begin
      @(negedge clk);
      if (ps2_clk_oe !== 1'b1) break;
      n++;
    end
    rel_cyc = cyc;
    chk("inhibit_len", n, INH + 1);
    chk("start_bit_driven", {31'd0, ps2_dat_oe}, 32'd1);
    fall_count    = 0;
    last_fall_cyc = cyc;
    mon_en        = 1'b1;
    cyc_wait(20);
    for (int k = 1; k <= max_falls; k++) begin
      @(posedge clk); #1;
      dev_clk       = 1'b0;
      fall_count    = k;
      last_fall_cyc = cyc;
      repeat (H) @(posedge clk);
      #1 dev_clk = 1'b1;
      repeat (H / 2) @(posedge clk);
      #1;
      if (k <= 11) cap[k] = ps2_dat_line;
      if (k == 11 && do_ack) dev_dat = 1'b0;
      if (k == 12) dev_dat = 1'b1;
      repeat (H - H / 2 - 1) @(posedge clk);
    end
  endtask

  task automatic wait_done(input int budget);
    got_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        got_done = 1'b1;
        done_cyc = cyc;
        d_err    = tx_err;
        d_busy   = tx_busy;
        d_coe    = ps2_clk_oe;
        d_doe    = ps2_dat_oe;
        break;
      end
    end
    chk("done_seen", {31'd0, got_done}, 32'd1);
    if (got_done) begin
      @(negedge clk);
      d_next = tx_done;
      chk("done_one_cycle", {31'd0, d_next}, 32'd0);
    end
  endtask

  task automatic check_completion(input logic [1:0] exp_err);
    chk("done_err", {30'd0, d_err}, {30'd0, exp_err});
    chk("done_busy_low", {31'd0, d_busy}, 32'd0);
    chk("done_clk_released", {31'd0, d_coe}, 32'd0);
    chk("done_dat_released", {31'd0, d_doe}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input logic [1:0] exp_err,
                           input logic [7:0] lit_byte, input bit lit_par, input bit inject);
    logic [7:0] b;
    cap = '1;
    model_data = d;
    pulse_start(d);
    fork
      dev_run(12, ack);
      wait_done(3000);
      begin
        if (inject) begin
          for (int i = 0; i < 2000 && fall_count < 4; i++) @(posedge clk);
          #1;
          pulse_start(8'h55);
          chk("busy_during_send", {31'd0, tx_busy}, 32'd1);
        end
      end
    join
    mon_en = 1'b0;
    for (int i = 0; i < 8; i++) b[i] = cap[i+2];
    chk("cap_start_bit", {31'd0, cap[1]}, 32'd0);
    chk("cap_data_byte", {24'd0, b}, {24'd0, lit_byte});
    chk("cap_parity", {31'd0, cap[10]}, {31'd0, lit_par});
    chk("cap_stop_bit", {31'd0, cap[11]}, 32'd1);
    check_completion(exp_err);
    cyc_wait(10);
    chk("err_holds", {30'd0, tx_err}, {30'd0, exp_err});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_wait(5);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_err", {30'd0, tx_err}, 32'd0);
    reset = 1'b0;
    cyc_wait(5);

    // 0xED: bits 1,0,1,1,0,1,1,1 LSB first, six ones -> parity 1
    run_frame(8'hED, 1'b1, 2'b00, 8'hED, 1'b1, 1'b0);
    // 0xF4: bits 0,0,1,0,1,1,1,1, five ones -> parity 0
    run_frame(8'hF4, 1'b1, 2'b00, 8'hF4, 1'b0, 1'b0);
    // device leaves data high at the ACK clock
    run_frame(8'hED, 1'b0, 2'b01, 8'hED, 1'b1, 1'b0);

    // device never clocks after the request-to-send
    model_data = 8'hED;
    pulse_start(8'hED);
    fork
      dev_run(0, 1'b0);
      wait_done(INH + START + 200);
    join
    mon_en = 1'b0;
    chk("start_timeout_cycles", done_cyc - rel_cyc, START);
    check_completion(2'b10);

    // 0x55 requested mid-frame must not disturb the 0xED frame
    run_frame(8'hED, 1'b1, 2'b00, 8'hED, 1'b1, 1'b1);

    // reset in the middle of SEND, then a clean frame
    model_data = 8'hED;
    pulse_start(8'hED);
    dev_run(5, 1'b1);
    mon_en = 1'b0;
    chk("busy_before_reset", {31'd0, tx_busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("midrst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    cyc_wait(2);
    reset = 1'b0;
    cyc_wait(5);
    run_frame(8'hF4, 1'b1, 2'b00, 8'hF4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte from the FPGA to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable.
- Performs the inhibit / request-to-send sequence, shifts the frame on device-generated clock edges, checks the device ACK and reports completion or error.
- Sits beside the PS/2 receiver in cpu_top and shares the open-drain PS2_CLK/PS2_DAT lines through top-level tristate buffers driven by the *_oe outputs.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the clock line is held low before RTS (100 us at 50 MHz).
- START_TIMEOUT, 750000: max cycles from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 100000: max cycles from the first falling edge to the end of the ACK (2 ms).

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send; sampled when tx_start is accepted
- tx_start  in  1  single-cycle request; accepted only in IDLE
- ps2_clk_in  in  1  raw PS2_CLK line (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT line (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release
- tx_busy  out  1  high from acceptance until completion
- tx_done  out  1  one-cycle pulse at completion (success or error)
- tx_err  out  2  valid with tx_done: 00 ok, 01 no ACK, 10 timeout; holds until next acceptance

Behaviour:
- Input synchronisation:
  - ps2_clk_in and ps2_dat_in each pass through a 2-FF synchroniser.
  - fall = previous synced clk 1 and current synced clk 0.
  - Response to a line edge lags by 3 cycles.
- Reset state: ps2_clk_oe=0, ps2_dat_oe=0, tx_busy=0, tx_done=0, tx_err=00, state IDLE, counters 0. Reset mid-transfer releases both lines on the next edge.
- IDLE:
  - On tx_start: latch shift = {parity, tx_data}, where parity = ~^tx_data (odd).
  - Set tx_busy=1 and go to INHIBIT.
  - tx_start while busy is ignored.
- INHIBIT: ps2_clk_oe=1. After INHIBIT_CYCLES cycles: set ps2_dat_oe=1 (start bit 0) and go to RTS.
- RTS:
  - The cycle after entry, ps2_clk_oe=0 while ps2_dat_oe stays 1.
  - Wait for a fall; on fall go to SEND with bit index 0 and reload the timeout counter.
  - START_TIMEOUT expiry goes to ERR with code 10.
- SEND (index 0..8):
  - On each fall: ps2_dat_oe = ~shift[index], then index++.
  - Index 0..7 carries the data bits LSB first; index 8 carries parity.
  - The fall after parity has been driven: ps2_dat_oe=0 (stop bit, released), go to ACK.
- ACK:
  - On the next fall, sample synced dat: 0 → go to WAIT_IDLE; 1 → go to ERR with code 01.
- WAIT_IDLE: wait until synced clk=1 and synced dat=1, then go to DONE.
- XFER_TIMEOUT:
  - Counts from RTS→SEND until leaving WAIT_IDLE, across all states.
  - Expiry goes to ERR with code 10.
- DONE: tx_done=1 for one cycle, tx_err=00, tx_busy=0, return to IDLE.
- ERR: both oe=0, tx_done=1 for one cycle with tx_err set, tx_busy=0, return to IDLE.
- Invariants:
  - ps2_clk_oe is 1 only in INHIBIT (plus the RTS entry cycle).
  - Never drive a line high.
  - A device clock edge occurring during INHIBIT is ignored.

Test Plan:
- Normal 0xED: reset → tx_start with 0xED; the bench device clocks at 10 kHz → clk_oe low for 5000 cycles, start bit 0, bits 1,0,1,1,0,1,1,1, parity 1, stop released; device ACK low → tx_done pulse, tx_err=00, tx_busy falls.
- Parity check with 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0, tx_err=00.
- No ACK: the device leaves dat high at the 11th clock → tx_done with tx_err=01, both oe=0.
- Start timeout: the device never clocks after RTS → tx_done with tx_err=10 at 750000 cycles after clock release; lines released.
- Busy and reset: tx_start 0x55 during SEND is ignored (frame still 0xED). Reset asserted mid-SEND → both oe=0 and tx_busy=0 the next cycle; a new tx_start after reset completes normally.
